mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Parametrised multicycle control unit for the RV32I datapath. It sequences fetch, decode, execute, memory and writeback, holding the current instruction in an internal instruction register. Compared with the fixed 4-phase controller it adds:
- per-class variable cycle counts;
- ready-based wait states on both memories;
- illegal-opcode trapping and a halt state;
- a parametrised retired-instruction counter.

It sits between instruction/data memory and the PC/regfile/ALU muxes.

## Interface
- XLEN, 32: datapath width; only affects `dbg_ir` width (fixed 32 when XLEN=32; XLEN=64 zero-extends).
- CNT_W, 32: width of retired-instruction counter.
- WAIT_EN, 1: 1 = honour `imem_ready`/`dmem_ready`; 0 = treat both as constantly 1.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-high.
- `instr_i` in 32: instruction memory read data, valid when `imem_ready`=1.
- `imem_ready` in 1: instruction read completes this cycle.
- `dmem_ready` in 1: data access completes this cycle.
- `br_taken_i` in 1: ALU compare result for the current branch, valid in EXEC.
- `imem_re` out 1: instruction read request.
- `ir_we` out 1: instruction register capture strobe (exported for debug).
- `pc_we` out 1: PC write enable.
- `pc_src` out 2: PC source. 00 = PC+4, 01 = PC+imm, 10 = (rs1+imm)&~1.
- `alu_a_sel` out 1: ALU A source. 0 = PC, 1 = rs1.
- `alu_b_sel` out 2: ALU B source. 00 = rs2, 01 = imm, 10 = const 4.
- `alu_op` out 4: ALU operation.
- `imm_sel` out 3: immediate format. 0 = I, 1 = S, 2 = B, 3 = U, 4 = J, 5 = shamt.
- `reg_we` out 1: register file write enable.
- `wb_sel` out 2: writeback source. 00 = ALU, 01 = mem, 10 = PC+4.
- `dmem_re` out 1: data read request.
- `dmem_we` out 1: data write request.
- `halted` out 1: ECALL/EBREAK reached.
- `illegal` out 1: unsupported encoding trapped.
- `retired` out CNT_W: count of completed instructions.
- `state_o` out 3: current state (debug).
- `dbg_ir` out 32: instruction register.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- FETCH
  - `imem_re`=1.
  - On `imem_ready`: IR←`instr_i`, `ir_we`=1, `pc_we`=1 with `pc_src`=00, then go to DECODE.
  - Otherwise hold.
- DECODE: drives `alu_a_sel`=0, `alu_b_sel`=01, `imm_sel`=B for branch-target precompute. Next state:
  - ECALL/EBREAK → HALT.
  - Unsupported opcode/funct → TRAP.
  - Everything else → EXEC.
- EXEC, by instruction class:
  - R-type: `alu_a_sel`=1, `alu_b_sel`=00. Ops: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SRL 0101, SRA 0110, SLT 0111, SLTU 1001, XOR 1101. Next: WB.
  - I-ALU: same op map as R-type, with `alu_b_sel`=01 and `imm_sel`=I (shifts use `imm_sel`=5). XORI=1101. Next: WB.
  - LW/SW: ADD, `alu_b_sel`=01, `imm_sel`=I/S. Next: MEM.
  - Branch: compare ops BEQ 1100, BNE 1011, BLT 0111, BGE 1000, BLTU 1001, BGEU 1010. `pc_we`=`br_taken_i`, `pc_src`=01. Next: FETCH (retire).
  - JAL: `pc_we`=1, `pc_src`=01, `imm_sel`=J. Next: WB.
  - JALR: `pc_we`=1, `pc_src`=10, `alu_op`=1110. Next: WB.
  - LUI/AUIPC: `imm_sel`=U, ADD. A = PC for AUIPC; for LUI, B = imm and rs1 is forced to 0 by the decoder. Next: WB.
- MEM
  - `dmem_re` (LW) or `dmem_we` (SW) is held until `dmem_ready`.
  - On `dmem_ready`: SW goes to FETCH (retire); LW goes to WB.
- WB: `reg_we`=1 for one cycle. `wb_sel`: 01 for LW, 10 for JAL/JALR, 00 otherwise. Next: FETCH (retire).
- Retire: `retired` increments by 1 on the cycle leaving the final state. It wraps modulo 2^CNT_W.
- HALT and TRAP are absorbing until reset. In both, all strobes are 0 and `halted`/`illegal` are held at 1.
- Writes to x0 are not suppressed here; the regfile suppresses them.

## Timing
- Control outputs are Moore-decoded from state and IR only; there is no combinational path from `instr_i`.
- The ready inputs feed the same-cycle `pc_we`/`ir_we` strobes and the next-state logic.
- Cycles per instruction, with zero wait:
  - Branch: 3.
  - SW: 4.
  - ALU, LUI, AUIPC, JAL, JALR: 4.
  - LW: 5.
- Each cycle with ready=0 in FETCH or MEM adds exactly 1 cycle.
- Reset (async assert):
  - state=FETCH, IR=0, `retired`=0, `halted`=0, `illegal`=0.
  - All outputs 0 except `imem_re`=1 (combinational from FETCH).
- Reset mid-instruction aborts it without retiring it. No `reg_we`/`dmem_we` is issued after reset asserts.
- `imem_ready` is ignored outside FETCH; `dmem_ready` is ignored outside MEM.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state enum;
  - ALU op constants;
  - opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011);
  - `pc_src`/`alu_b_sel`/`wb_sel`/`imm_sel` encodings.
- One sub-module, `mc_decode`: purely combinational. Maps IR to class, `alu_op`, `imm_sel`, and an illegal flag.
- The FSM, IR, and counter live in the top module.

## Test plan
- ADD x3,x1,x2 (0x002081B3), ready=1 → states 0,1,2,4,0.
  - EXEC: `alu_op`=0000, `alu_b_sel`=00.
  - WB: `reg_we`=1, `wb_sel`=00.
  - `retired`=1 after 4 cycles.
- LW (0x0000A183) with `dmem_ready` low 2 cycles:
  - `dmem_re` is held for 3 MEM cycles.
  - WB has `wb_sel`=01; 7 cycles total.
- BNE with `br_taken_i`=1: EXEC has `alu_op`=1011, `pc_we`=1, `pc_src`=01, then returns to FETCH. With `br_taken_i`=0: `pc_we`=0.
- Illegal word 0xFFFFFFFF → TRAP: `illegal`=1, all strobes 0 for 10 cycles, `retired` unchanged.
- Reset asserted in MEM of a SW: no `dmem_we` after reset; on release state=FETCH, `retired`=0.
- CNT_W=4: 16 back-to-back ADDI instructions → `retired` wraps to 0. Also ECALL (0x00000073) → `halted`=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// instruction classes, ALU operations, opcodes and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_TRAP   = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
      CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYS, CLS_ILL
   } cls_e;

   // ALU operation codes (branch compares share the same field)
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_BGE  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_BGEU = 4'b1010;
   localparam logic [3:0] ALU_BNE  = 4'b1011;
   localparam logic [3:0] ALU_BEQ  = 4'b1100;
   localparam logic [3:0] ALU_XOR  = 4'b1101;
   localparam logic [3:0] ALU_JALR = 4'b1110;

   // Major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Datapath mux encodings
   localparam logic [1:0] PC_SRC_PC4  = 2'b00;
   localparam logic [1:0] PC_SRC_IMM  = 2'b01;
   localparam logic [1:0] PC_SRC_JALR = 2'b10;

   localparam logic [1:0] ALUB_RS2  = 2'b00;
   localparam logic [1:0] ALUB_IMM  = 2'b01;
   localparam logic [1:0] ALUB_FOUR = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [2:0] IMM_I     = 3'd0;
   localparam logic [2:0] IMM_S     = 3'd1;
   localparam logic [2:0] IMM_B     = 3'd2;
   localparam logic [2:0] IMM_U     = 3'd3;
   localparam logic [2:0] IMM_J     = 3'd4;
   localparam logic [2:0] IMM_SHAMT = 3'd5;

   // funct3 (+ the funct7 alternate bit) to ALU op for OP / OP-IMM
   function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies the instruction register and
// derives the ALU operation, immediate format and an illegal-encoding flag.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [31:0] ir_i,
   output cls_e        cls_o,
   output logic [3:0]  alu_op_o,
   output logic [2:0]  imm_sel_o,
   output logic        illegal_o
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = ir_i[6:0];
   assign f3  = ir_i[14:12];
   assign f7  = ir_i[31:25];

   // Classify; anything not matched explicitly stays CLS_ILL
   always_comb begin
      cls_o     = CLS_ILL;
      alu_op_o  = ALU_ADD;
      imm_sel_o = IMM_I;
      case (opc)
         OPC_OP: begin
            if ((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
               cls_o    = CLS_R;
               alu_op_o = alu_fn(f3, f7[5]);
            end
         end
         OPC_OPIMM: begin
            if (f3 == 3'b001) begin
               if (f7 == 7'b0000000) begin
                  cls_o     = CLS_IALU;
                  alu_op_o  = ALU_SLL;
                  imm_sel_o = IMM_SHAMT;
               end
            end else if (f3 == 3'b101) begin
               if ((f7 == 7'b0000000) || (f7 == 7'b0100000)) begin
                  cls_o     = CLS_IALU;
                  alu_op_o  = alu_fn(f3, f7[5]);
                  imm_sel_o = IMM_SHAMT;
               end
            end else begin
               cls_o    = CLS_IALU;
               alu_op_o = alu_fn(f3, 1'b0);
            end
         end
         OPC_LOAD: begin
            if (f3 == 3'b010) cls_o = CLS_LOAD;
         end
         OPC_STORE: begin
            if (f3 == 3'b010) begin
               cls_o     = CLS_STORE;
               imm_sel_o = IMM_S;
            end
         end
         OPC_BRANCH: begin
            imm_sel_o = IMM_B;
            cls_o     = CLS_BRANCH;
            case (f3)
               3'b000:  alu_op_o = ALU_BEQ;
               3'b001:  alu_op_o = ALU_BNE;
               3'b100:  alu_op_o = ALU_SLT;
               3'b101:  alu_op_o = ALU_BGE;
               3'b110:  alu_op_o = ALU_SLTU;
               3'b111:  alu_op_o = ALU_BGEU;
               default: cls_o    = CLS_ILL;
            endcase
         end
         OPC_JAL: begin
            cls_o     = CLS_JAL;
            imm_sel_o = IMM_J;
         end
         OPC_JALR: begin
            if (f3 == 3'b000) begin
               cls_o    = CLS_JALR;
               alu_op_o = ALU_JALR;
            end
         end
         OPC_LUI: begin
            cls_o     = CLS_LUI;
            imm_sel_o = IMM_U;
         end
         OPC_AUIPC: begin
            cls_o     = CLS_AUIPC;
            imm_sel_o = IMM_U;
         end
         OPC_SYSTEM: begin
            // only ECALL and EBREAK; CSR accesses are not supported
            if ((ir_i == 32'h0000_0073) || (ir_i == 32'h0010_0073)) cls_o = CLS_SYS;
         end
         default: cls_o = CLS_ILL;
      endcase
   end

   assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory wait states, ECALL/EBREAK halt, illegal-encoding trap and a
// retired-instruction counter. Outputs are decoded from state and IR only.
//
// Memory handshake: imem_re / dmem_re / dmem_we are requests held high for
// as long as the FSM sits in FETCH / MEM. A request completes in the cycle
// its ready input is 1; the FSM advances on that clock edge. imem_ready is
// ignored outside FETCH and dmem_ready outside MEM.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int CNT_W   = 32,
   parameter bit WAIT_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      instr_i,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             br_taken_i,
   output logic             imem_re,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             alu_a_sel,
   output logic [1:0]       alu_b_sel,
   output logic [3:0]       alu_op,
   output logic [2:0]       imm_sel,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic             dmem_re,
   output logic             dmem_we,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state_o,
   output logic [XLEN-1:0]  dbg_ir
);

   state_e           state_q, state_d;
   logic [31:0]      ir_q;
   logic [CNT_W-1:0] retired_q;
   logic             retire_s;

   cls_e             dec_cls;
   logic [3:0]       dec_alu_op;
   logic [2:0]       dec_imm_sel;
   logic             dec_illegal;

   logic             imem_rdy, dmem_rdy;
   logic             dp_a_sel;
   logic [1:0]       dp_b_sel;

   assign imem_rdy = WAIT_EN ? imem_ready : 1'b1;
   assign dmem_rdy = WAIT_EN ? dmem_ready : 1'b1;

   mc_decode u_dec (
      .ir_i      (ir_q),
      .cls_o     (dec_cls),
      .alu_op_o  (dec_alu_op),
      .imm_sel_o (dec_imm_sel),
      .illegal_o (dec_illegal)
   );

   // Operand selects kept stable through EXEC, MEM and WB of one instruction
   assign dp_a_sel = !((dec_cls == CLS_AUIPC) || (dec_cls == CLS_JAL));
   assign dp_b_sel = ((dec_cls == CLS_R) || (dec_cls == CLS_BRANCH)) ? ALUB_RS2 : ALUB_IMM;

   // State, instruction register and retired counter
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q   <= ST_FETCH;
         ir_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (ir_we)    ir_q      <= instr_i;
         if (retire_s) retired_q <= retired_q + CNT_W'(1);
      end
   end

   // Next-state and Moore control decode
   always_comb begin
      state_d   = state_q;
      retire_s  = 1'b0;
      imem_re   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PC_SRC_PC4;
      alu_a_sel = 1'b0;
      alu_b_sel = ALUB_RS2;
      alu_op    = ALU_ADD;
      imm_sel   = IMM_I;
      reg_we    = 1'b0;
      wb_sel    = WB_ALU;
      dmem_re   = 1'b0;
      dmem_we   = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_re = 1'b1;
            if (imem_rdy) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               pc_src  = PC_SRC_PC4;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            // precompute PC + B-immediate as a branch target
            alu_a_sel = 1'b0;
            alu_b_sel = ALUB_IMM;
            imm_sel   = IMM_B;
            if (dec_cls == CLS_SYS)  state_d = ST_HALT;
            else if (dec_illegal)    state_d = ST_TRAP;
            else                     state_d = ST_EXEC;
         end
         ST_EXEC: begin
            alu_a_sel = dp_a_sel;
            alu_b_sel = dp_b_sel;
            alu_op    = dec_alu_op;
            imm_sel   = dec_imm_sel;
            case (dec_cls)
               CLS_R, CLS_IALU, CLS_LUI, CLS_AUIPC: state_d = ST_WB;
               CLS_LOAD, CLS_STORE:                 state_d = ST_MEM;
               CLS_BRANCH: begin
                  pc_we    = br_taken_i;
                  pc_src   = PC_SRC_IMM;
                  state_d  = ST_FETCH;
                  retire_s = 1'b1;
               end
               CLS_JAL: begin
                  pc_we   = 1'b1;
                  pc_src  = PC_SRC_IMM;
                  state_d = ST_WB;
               end
               CLS_JALR: begin
                  pc_we   = 1'b1;
                  pc_src  = PC_SRC_JALR;
                  state_d = ST_WB;
               end
               default: state_d = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            alu_a_sel = dp_a_sel;
            alu_b_sel = dp_b_sel;
            alu_op    = dec_alu_op;
            imm_sel   = dec_imm_sel;
            dmem_re   = (dec_cls == CLS_LOAD);
            dmem_we   = (dec_cls == CLS_STORE);
            if (dmem_rdy) begin
               if (dec_cls == CLS_STORE) begin
                  state_d  = ST_FETCH;
                  retire_s = 1'b1;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            alu_a_sel = dp_a_sel;
            alu_b_sel = dp_b_sel;
            alu_op    = dec_alu_op;
            imm_sel   = dec_imm_sel;
            reg_we    = 1'b1;
            if (dec_cls == CLS_LOAD)                                wb_sel = WB_MEM;
            else if ((dec_cls == CLS_JAL) || (dec_cls == CLS_JALR)) wb_sel = WB_PC4;
            else                                                    wb_sel = WB_ALU;
            state_d  = ST_FETCH;
            retire_s = 1'b1;
         end
         ST_HALT: halted  = 1'b1;
         ST_TRAP: illegal = 1'b1;
         default: state_d = ST_TRAP;
      endcase
   end

   assign retired = retired_q;
   assign state_o = state_q;
   assign dbg_ir  = XLEN'(ir_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: reset values, per-class control fields
// and cycle counts, memory wait states, branch taken/not-taken, trap, halt,
// reset during a store and counter wrap on a CNT_W=4 instance.
module tb_mc_control_fsm;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [31:0] instr_i;
   logic        imem_ready, dmem_ready, br_taken_i;

   logic        imem_re, ir_we, pc_we, alu_a_sel, reg_we, dmem_re, dmem_we, halted, illegal;
   logic [1:0]  pc_src, alu_b_sel, wb_sel;
   logic [3:0]  alu_op;
   logic [2:0]  imm_sel, state_o;
   logic [31:0] retired, dbg_ir;

   logic        d4_imem_re, d4_ir_we, d4_pc_we, d4_alu_a_sel, d4_reg_we, d4_dmem_re, d4_dmem_we;
   logic        d4_halted, d4_illegal;
   logic [1:0]  d4_pc_src, d4_alu_b_sel, d4_wb_sel;
   logic [3:0]  d4_alu_op, d4_retired;
   logic [2:0]  d4_imm_sel, d4_state;
   logic [31:0] d4_dbg_ir;

   mc_control_fsm dut (
      .clk(clk), .rstn(rstn), .instr_i(instr_i), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .br_taken_i(br_taken_i), .imem_re(imem_re),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
      .alu_b_sel(alu_b_sel), .alu_op(alu_op), .imm_sel(imm_sel), .reg_we(reg_we),
      .wb_sel(wb_sel), .dmem_re(dmem_re), .dmem_we(dmem_we), .halted(halted),
      .illegal(illegal), .retired(retired), .state_o(state_o), .dbg_ir(dbg_ir)
   );

   mc_control_fsm #(.CNT_W(4)) dut4 (
      .clk(clk), .rstn(rstn), .instr_i(instr_i), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .br_taken_i(br_taken_i), .imem_re(d4_imem_re),
      .ir_we(d4_ir_we), .pc_we(d4_pc_we), .pc_src(d4_pc_src), .alu_a_sel(d4_alu_a_sel),
      .alu_b_sel(d4_alu_b_sel), .alu_op(d4_alu_op), .imm_sel(d4_imm_sel), .reg_we(d4_reg_we),
      .wb_sel(d4_wb_sel), .dmem_re(d4_dmem_re), .dmem_we(d4_dmem_we), .halted(d4_halted),
      .illegal(d4_illegal), .retired(d4_retired), .state_o(d4_state), .dbg_ir(d4_dbg_ir)
   );

   logic [5:0] strobes;
   assign strobes = {imem_re, ir_we, pc_we, reg_we, dmem_re, dmem_we};

   // ---------------- checking ----------------
   int err_cnt = 0;
   int chk_cnt = 0;
   int rst_viol = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // register/memory writes must never be seen while reset is held
   always @(negedge clk) if (rstn && (reg_we || dmem_we)) rst_viol++;

   // ---------------- stimulus vectors ----------------
   typedef struct {
      logic [31:0] instr;
      logic        br;
      logic [3:0]  op;
      logic [2:0]  imm;
      logic        a;
      logic [1:0]  b;
      logic        pcwe;
      logic [1:0]  pcsrc;
      logic        has_wb;
      logic [1:0]  wb;
      int          cpi;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs[NV];
   vec_t v_add, v_lw, v_addi;

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rstn       = 1'b1;
      instr_i    = 32'h0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      br_taken_i = 1'b0;
      #2;
      check("rst state", 32'(state_o), 32'd0);
      check("rst strobes", 32'(strobes), 32'b100000);
      check("rst muxes", {alu_a_sel, alu_b_sel, alu_op, imm_sel, pc_src, wb_sel}, 32'd0);
      check("rst flags", {halted, illegal}, 32'd0);
      check("rst retired", retired, 32'd0);
      check("rst ir", dbg_ir, 32'd0);
      tick;
      rstn = 1'b0;
   endtask

   // Runs one instruction from FETCH to retirement, checking each state.
   task automatic run_one(input string nm, input vec_t v, input int iwait, input int dwait);
      logic [31:0] r0;
      int          cyc, fcnt, mcnt;
      bit          seen_wb, done;
      logic        is_ld, is_st;
      r0 = retired; cyc = 0; fcnt = 0; mcnt = 0; seen_wb = 0; done = 0;
      is_ld = (v.instr[6:0] == 7'b0000011);
      is_st = (v.instr[6:0] == 7'b0100011);
      instr_i    = v.instr;
      br_taken_i = v.br;
      while (!done && cyc < 40) begin
         if (state_o == 3'd0) begin imem_ready = (fcnt >= iwait); fcnt++; end
         else imem_ready = 1'b1;
         if (state_o == 3'd3) begin dmem_ready = (mcnt >= dwait); mcnt++; end
         else dmem_ready = 1'b1;
         #1;
         case (state_o)
            3'd0: check({nm, " fetch"}, {imem_re, ir_we, pc_we, pc_src},
                        {1'b1, imem_ready, imem_ready, 2'b00});
            3'd1: check({nm, " decode"}, {alu_a_sel, alu_b_sel, imm_sel, strobes},
                        {1'b0, 2'b01, 3'd2, 6'b0});
            3'd2: begin
               check({nm, " exec"}, {alu_op, imm_sel, alu_a_sel, alu_b_sel, pc_we, pc_src},
                     {v.op, v.imm, v.a, v.b, v.pcwe, v.pcsrc});
               check({nm, " ir"}, dbg_ir, v.instr);
            end
            3'd3: check({nm, " mem"}, {dmem_re, dmem_we, reg_we}, {is_ld, is_st, 1'b0});
            3'd4: begin
               seen_wb = 1;
               check({nm, " wb"}, {reg_we, wb_sel, dmem_re, dmem_we}, {1'b1, v.wb, 2'b00});
            end
            default: check({nm, " state"}, 32'(state_o), 32'd0);
         endcase
         tick;
         cyc++;
         if (retired != r0) done = 1;
      end
      check({nm, " cycles"}, cyc, v.cpi + iwait + dwait);
      check({nm, " wb seen"}, 32'(seen_wb), 32'(v.has_wb));
      check({nm, " retired"}, retired, r0 + 32'd1);
      imem_ready = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [5:0] acc;
      //                 instr         br   op       imm  a  b      pcwe pcsrc has_wb wb   cpi
      v_add  = '{32'h002081B3, 1'b0, 4'b0000, 3'd0, 1, 2'b00, 0, 2'b00, 1, 2'b00, 4};
      v_lw   = '{32'h0000A183, 1'b0, 4'b0000, 3'd0, 1, 2'b01, 0, 2'b00, 1, 2'b01, 5};
      v_addi = '{32'h00100093, 1'b0, 4'b0000, 3'd0, 1, 2'b01, 0, 2'b00, 1, 2'b00, 4};
      vecs[0]  = v_add;
      vecs[1]  = '{32'h402081B3, 1'b0, 4'b0001, 3'd0, 1, 2'b00, 0, 2'b00, 1, 2'b00, 4}; // SUB
      vecs[2]  = '{32'h40315093, 1'b0, 4'b0110, 3'd5, 1, 2'b01, 0, 2'b00, 1, 2'b00, 4}; // SRAI
      vecs[3]  = '{32'h00514093, 1'b0, 4'b1101, 3'd0, 1, 2'b01, 0, 2'b00, 1, 2'b00, 4}; // XORI
      vecs[4]  = v_lw;
      vecs[5]  = '{32'h0020A023, 1'b0, 4'b0000, 3'd1, 1, 2'b01, 0, 2'b00, 0, 2'b00, 4}; // SW
      vecs[6]  = '{32'h00209463, 1'b1, 4'b1011, 3'd2, 1, 2'b00, 1, 2'b01, 0, 2'b00, 3}; // BNE taken
      vecs[7]  = '{32'h00209463, 1'b0, 4'b1011, 3'd2, 1, 2'b00, 0, 2'b01, 0, 2'b00, 3}; // BNE not taken
      vecs[8]  = '{32'h0020F463, 1'b1, 4'b1010, 3'd2, 1, 2'b00, 1, 2'b01, 0, 2'b00, 3}; // BGEU
      vecs[9]  = '{32'h008000EF, 1'b0, 4'b0000, 3'd4, 0, 2'b01, 1, 2'b01, 1, 2'b10, 4}; // JAL
      vecs[10] = '{32'h000100E7, 1'b0, 4'b1110, 3'd0, 1, 2'b01, 1, 2'b10, 1, 2'b10, 4}; // JALR
      vecs[11] = '{32'h123450B7, 1'b0, 4'b0000, 3'd3, 1, 2'b01, 0, 2'b00, 1, 2'b00, 4}; // LUI
      vecs[12] = '{32'h00000097, 1'b0, 4'b0000, 3'd3, 0, 2'b01, 0, 2'b00, 1, 2'b00, 4}; // AUIPC
      vecs[13] = v_addi;

      do_reset;
      for (int i = 0; i < NV; i++) run_one($sformatf("v%0d", i), vecs[i], 0, 0);
      check("retired after table", retired, 32'(NV));

      // wait states: 2 cycles on dmem, 3 cycles on imem
      run_one("lw wait", v_lw, 0, 2);
      run_one("add iwait", v_add, 3, 0);

      // illegal word traps; nothing moves for 10 cycles
      do_reset;
      instr_i = 32'hFFFF_FFFF; imem_ready = 1'b1;
      tick; tick;
      check("trap state", 32'(state_o), 32'd6);
      instr_i = v_add.instr; dmem_ready = 1'b1; br_taken_i = 1'b1;
      acc = '0;
      for (int i = 0; i < 10; i++) begin
         acc |= strobes;
         if (!illegal) acc[0] = 1'b1;
         tick;
      end
      check("trap strobes", 32'(acc), 32'd0);
      check("trap retired", retired, 32'd0);
      check("trap hold", {28'd0, illegal, state_o}, 32'b1110);

      // unsupported funct7 on an R-type also traps
      do_reset;
      instr_i = 32'h4020F1B3; imem_ready = 1'b1;
      tick; imem_ready = 1'b0; tick;
      check("bad funct trap", {28'd0, illegal, state_o}, 32'b1110);

      // reset asserted while a store waits in MEM
      do_reset;
      run_one("pre add", v_add, 0, 0);
      instr_i = 32'h0020A023; imem_ready = 1'b1;
      tick; imem_ready = 1'b0; dmem_ready = 1'b0;
      tick; tick;
      check("sw in mem", {dmem_we, 1'b0, state_o}, 32'b10011);
      #2 rstn = 1'b1;
      #1;
      check("sw reset abort", {dmem_we, reg_we, 1'b0, state_o}, 32'd0);
      dmem_ready = 1'b1;
      tick; tick;
      rstn = 1'b0;
      #1;
      check("sw reset release", {26'd0, dmem_we, reg_we, 1'b0, state_o}, 32'd0);
      check("sw reset retired", retired, 32'd0);
      check("no writes in reset", rst_viol, 32'd0);

      // counter wrap on the 4-bit instance, then ECALL halts
      do_reset;
      for (int i = 0; i < 16; i++) run_one($sformatf("addi%0d", i), v_addi, 0, 0);
      check("cnt4 wrap", 32'(d4_retired), 32'd0);
      check("cnt32 sixteen", retired, 32'd16);
      instr_i = 32'h0000_0073; imem_ready = 1'b1;
      tick; imem_ready = 1'b0; tick;
      check("halt state", {28'd0, halted, state_o}, 32'b1101);
      imem_ready = 1'b1;
      tick; tick; tick;
      check("halt strobes", {26'd0, strobes}, 32'd0);
      check("halt hold", {illegal, halted, d4_halted}, 32'b011);
      check("halt retired", retired, 32'd16);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   // hard stop if the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL timeout: sequence did not complete");
      $fatal(1);
   end

endmodule
